infix_postfix_sched: RTL

- Token scheduler between the keypad/token decoder and the postfix evaluator of the calculator.
- Accepts an infix token stream (operands and operators + − × plus an END marker) and reorders it into postfix (RPN) order, using shunting-yard with an internal operator stack.
- Emits postfix tokens one at a time over a valid/ready handshake, so the evaluator consumes operands and operators in execution order.
- Unary minus is resolved upstream and arrives as a signed operand.

---
 rtl/infix_postfix_sched.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/infix_postfix_sched.sv
// infix_postfix_sched
// Token scheduler between the keypad/token decoder and the postfix evaluator.
// Reorders an infix token stream (operands, ADD/SUB/MUL, END) into postfix
// order with a shunting-yard operator stack, and emits one token per
// valid/ready handshake so the evaluator sees tokens in execution order.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      input token handshake
//   in_is_op, in_op, in_data input token (op codes: 00 ADD, 01 SUB, 10 MUL, 11 END)
//   out_valid / out_ready    output token handshake
//   out_is_op, out_op, out_data  output token
//   busy                     scheduler is not in ACCEPT
//   err                      operator stack overflow, sticky until rst
module infix_postfix_sched #(
    parameter int DATA_W    = 16,
    parameter int STK_DEPTH = 8,
    parameter int PTR_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_op,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_is_op,
    output logic [1:0]        out_op,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              err
);

    localparam logic [1:0]     OP_MUL  = 2'b10;
    localparam logic [1:0]     OP_END  = 2'b11;
    localparam logic [PTR_W:0] SP_ONE  = 1;
    localparam logic [PTR_W:0] SP_FULL = (PTR_W + 1)'(STK_DEPTH);

    typedef enum logic [2:0] {
        S_ACCEPT,
        S_REDUCE,
        S_PUSH,
        S_FLUSH,
        S_ERR
    } state_t;

    state_t            state, state_nx;
    logic [1:0]        stack [STK_DEPTH];
    // One bit wider than the index so "full" is distinguishable from "empty".
    logic [PTR_W:0]    sp;
    logic [PTR_W-1:0]  top_idx;
    logic [1:0]        top_op;
    logic [1:0]        pending, pending_nx;
    logic              stack_empty, stack_full, loadable;
    logic              load, ld_is_op;
    logic [1:0]        ld_op;
    logic [DATA_W-1:0] ld_data;
    logic              do_push, do_pop, set_err;

    function automatic logic [1:0] prec(input logic [1:0] op);
        return (op == OP_MUL) ? 2'd2 : 2'd1;
    endfunction

    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == SP_FULL);
    assign top_idx     = PTR_W'(sp - SP_ONE);
    assign top_op      = stack[top_idx];
    // The output register can take a new token if it is empty or being drained now.
    assign loadable    = ~out_valid | out_ready;
    assign in_ready    = (state == S_ACCEPT) & ~err & loadable;
    assign busy        = (state != S_ACCEPT);

    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        load       = 1'b0;
        ld_is_op   = 1'b0;
        ld_op      = 2'b00;
        ld_data    = '0;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        set_err    = 1'b0;
        case (state)
            S_ACCEPT: begin
                if (in_valid && in_ready) begin
                    if (!in_is_op) begin
                        load    = 1'b1;
                        ld_data = in_data;
                    end else if (in_op == OP_END) begin
                        state_nx = S_FLUSH;
                    end else begin
                        pending_nx = in_op;
                        state_nx   = S_REDUCE;
                    end
                end
            end
            S_REDUCE: begin
                // Left associativity: equal precedence also pops.
                if (!stack_empty && (prec(top_op) >= prec(pending))) begin
                    if (loadable) begin
                        load     = 1'b1;
                        ld_is_op = 1'b1;
                        ld_op    = top_op;
                        do_pop   = 1'b1;
                    end
                end else begin
                    state_nx = S_PUSH;
                end
            end
            S_PUSH: begin
                if (stack_full) begin
                    set_err  = 1'b1;
                    state_nx = S_ERR;
                end else begin
                    do_push  = 1'b1;
                    state_nx = S_ACCEPT;
                end
            end
            S_FLUSH: begin
                if (loadable) begin
                    load     = 1'b1;
                    ld_is_op = 1'b1;
                    if (!stack_empty) begin
                        ld_op  = top_op;
                        do_pop = 1'b1;
                    end else begin
                        ld_op    = OP_END;
                        state_nx = S_ACCEPT;
                    end
                end
            end
            S_ERR: begin
                state_nx = S_ERR;
            end
            default: begin
                state_nx = S_ACCEPT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_ACCEPT;
            sp        <= '0;
            pending   <= 2'b00;
            out_valid <= 1'b0;
            out_is_op <= 1'b0;
            out_op    <= 2'b00;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            state   <= state_nx;
            pending <= pending_nx;
            if (do_pop) begin
                sp <= sp - SP_ONE;
            end else if (do_push) begin
                sp <= sp + SP_ONE;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_is_op <= ld_is_op;
                out_op    <= ld_op;
                out_data  <= ld_data;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (set_err) begin
                err <= 1'b1;
            end
        end
    end

    // Stack contents need no reset: the pointer alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack[sp[PTR_W-1:0]] <= pending;
        end
    end

endmodule
